// File: rtl/rb_pkg.sv
// Shared constants and types for the register-bank writeback scheduler.
package rb_pkg;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;

    localparam logic [AW-1:0] REG_ZERO = {AW{1'b0}};

    localparam logic [1:0] SRC_SKID = 2'd0;
    localparam logic [1:0] SRC_MEM  = 2'd1;
    localparam logic [1:0] SRC_ALU  = 2'd2;

    typedef struct packed {
        logic [AW-1:0] dr;
        logic [DW-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_skid_buf.sv
// One-entry holding register for a writeback request that lost arbitration.
module wb_skid_buf
    import rb_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          drain,
    input  logic [AW-1:0] load_dr,
    input  logic [DW-1:0] load_data,
    output logic          valid,
    output logic [AW-1:0] dr,
    output logic [DW-1:0] data
);

    logic    valid_r;
    wb_req_t entry_r;

    // Entry register: a load in the same cycle as a drain replaces the entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
            entry_r <= {($bits(wb_req_t)){1'b0}};
        end else if (load) begin
            valid_r      <= 1'b1;
            entry_r.dr   <= load_dr;
            entry_r.data <= load_data;
        end else if (drain) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign valid = valid_r;
    assign dr    = entry_r.dr;
    assign data  = entry_r.data;

endmodule

// File: rtl/regbank_wb_scheduler.sv
// Write-port arbiter and busy-bit scoreboard for the 32-entry register bank.
module regbank_wb_scheduler
    import rb_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_sr1,
    input  logic [AW-1:0]   iss_sr2,
    input  logic [AW-1:0]   iss_dr,
    input  logic            iss_wr,
    output logic            iss_stall,
    input  logic            alu_wb_valid,
    input  logic [AW-1:0]   alu_wb_dr,
    input  logic [DW-1:0]   alu_wb_data,
    output logic            alu_wb_ready,
    input  logic            mem_wb_valid,
    input  logic [AW-1:0]   mem_wb_dr,
    input  logic [DW-1:0]   mem_wb_data,
    output logic            mem_wb_ready,
    output logic            rf_write,
    output logic [AW-1:0]   rf_dr,
    output logic [DW-1:0]   rf_wrData,
    output logic [NREG-1:0] busy,
    output logic            wb_err
);

    logic            skid_valid_s;
    logic [AW-1:0]   skid_dr_s;
    logic [DW-1:0]   skid_data_s;
    logic            gnt_valid_s;
    logic [1:0]      gnt_src_s;
    wb_req_t         gnt_req_s;
    logic            skid_free_s;
    logic            mem_cap_s;
    logic            alu_cap_s;
    logic            skid_load_s;
    logic            skid_drain_s;
    logic [AW-1:0]   skid_ld_dr_s;
    logic [DW-1:0]   skid_ld_data_s;
    logic            iss_accept_s;
    logic            commit_s;
    logic [NREG-1:0] busy_nxt_s;
    logic            rf_write_r;
    logic [AW-1:0]   rf_dr_r;
    logic [DW-1:0]   rf_wrdata_r;
    logic [NREG-1:0] busy_r;
    logic            wb_err_r;

    wb_skid_buf u_skid (
        .clk       (clk),
        .reset     (reset),
        .load      (skid_load_s),
        .drain     (skid_drain_s),
        .load_dr   (skid_ld_dr_s),
        .load_data (skid_ld_data_s),
        .valid     (skid_valid_s),
        .dr        (skid_dr_s),
        .data      (skid_data_s)
    );

    // Fixed-priority grant: skid, then mem, then alu.
    always_comb begin
        gnt_valid_s = 1'b1;
        gnt_src_s   = SRC_SKID;
        if (skid_valid_s) begin
            gnt_src_s = SRC_SKID;
        end else if (mem_wb_valid) begin
            gnt_src_s = SRC_MEM;
        end else if (alu_wb_valid) begin
            gnt_src_s = SRC_ALU;
        end else begin
            gnt_valid_s = 1'b0;
        end
        case (gnt_src_s)
            SRC_SKID: gnt_req_s = '{dr: skid_dr_s,  data: skid_data_s};
            SRC_MEM:  gnt_req_s = '{dr: mem_wb_dr,  data: mem_wb_data};
            SRC_ALU:  gnt_req_s = '{dr: alu_wb_dr,  data: alu_wb_data};
            default:  gnt_req_s = {($bits(wb_req_t)){1'b0}};
        endcase
    end

    // Losers are parked in the skid when it is free; mem takes precedence.
    always_comb begin
        skid_free_s  = !skid_valid_s || (gnt_valid_s && gnt_src_s == SRC_SKID);
        skid_drain_s = gnt_valid_s && gnt_src_s == SRC_SKID;
        mem_cap_s    = mem_wb_valid && gnt_src_s != SRC_MEM && skid_free_s;
        alu_cap_s    = alu_wb_valid && gnt_src_s != SRC_ALU && skid_free_s && !mem_cap_s;
        skid_load_s  = mem_cap_s || alu_cap_s;
        if (mem_cap_s) begin
            skid_ld_dr_s   = mem_wb_dr;
            skid_ld_data_s = mem_wb_data;
        end else begin
            skid_ld_dr_s   = alu_wb_dr;
            skid_ld_data_s = alu_wb_data;
        end
        mem_wb_ready = mem_wb_valid && ((gnt_valid_s && gnt_src_s == SRC_MEM) || mem_cap_s);
        alu_wb_ready = alu_wb_valid && ((gnt_valid_s && gnt_src_s == SRC_ALU) || alu_cap_s);
    end

    // Scoreboard update: the clear of a committing register is applied first so a same-edge set wins.
    always_comb begin
        iss_stall    = iss_valid && (busy_r[iss_sr1] || busy_r[iss_sr2] || (iss_wr && busy_r[iss_dr]));
        iss_accept_s = iss_valid && !iss_stall;
        commit_s     = rf_write_r && rf_dr_r != REG_ZERO;
        busy_nxt_s   = busy_r;
        if (commit_s) begin
            busy_nxt_s[rf_dr_r] = 1'b0;
        end else begin
            busy_nxt_s = busy_r;
        end
        if (iss_accept_s && iss_wr && iss_dr != REG_ZERO) begin
            busy_nxt_s[iss_dr] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
    end

    // Write-port, scoreboard and error state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_write_r  <= 1'b0;
            rf_dr_r     <= REG_ZERO;
            rf_wrdata_r <= {DW{1'b0}};
            busy_r      <= {NREG{1'b0}};
            wb_err_r    <= 1'b0;
        end else begin
            rf_write_r  <= gnt_valid_s;
            rf_dr_r     <= gnt_valid_s ? gnt_req_s.dr : REG_ZERO;
            rf_wrdata_r <= gnt_valid_s ? gnt_req_s.data : {DW{1'b0}};
            busy_r      <= busy_nxt_s;
            wb_err_r    <= wb_err_r || (commit_s && !busy_r[rf_dr_r]);
        end
    end

    assign rf_write  = rf_write_r;
    assign rf_dr     = rf_dr_r;
    assign rf_wrData = rf_wrdata_r;
    assign busy      = busy_r;
    assign wb_err    = wb_err_r;

endmodule
